// File: rtl/mem_arbiter2.sv
// Two-port arbiter sharing one single-ported RAM between a CPU (port 0) and an
// auxiliary master (port 1). Each port has a one-deep request slot; reads return one cycle after issue.
module mem_arbiter2 #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_rstrb,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wmask,
  output logic [31:0]           m0_rdata,
  output logic                  m0_busy,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_rstrb,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wmask,
  output logic [31:0]           m1_rdata,
  output logic                  m1_busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rstrb,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned MASK_WIDTH = 4;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_WIDTH-1:0] wmask;
    logic                  is_read;
  } req_t;

  logic pending0;
  logic pending1;
  req_t slot0;
  req_t slot1;
  logic rd_inflight;
  logic rd_owner;
  logic last_grant;

  logic gnt_valid;
  logic gnt_port;
  req_t gnt_req;
  logic req0;
  logic req1;
  logic issue_read;

  // Busy is purely a function of state, so it never depends on this cycle's inputs.
  assign m0_busy = pending0 | (rd_inflight & ~rd_owner);
  assign m1_busy = pending1 | (rd_inflight &  rd_owner);

  // A new pulse is accepted only from an idle port; pulses while busy are dropped.
  assign req0 = ~m0_busy & (m0_rstrb | (|m0_wmask));
  assign req1 = ~m1_busy & (m1_rstrb | (|m1_wmask));

  // Grant selection over the pending slots.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_port  = 1'b0;
    if (pending0 && pending1) begin
      gnt_valid = 1'b1;
      gnt_port  = FIXED_PRIO ? 1'b0 : ~last_grant;
    end else if (pending0) begin
      gnt_valid = 1'b1;
      gnt_port  = 1'b0;
    end else if (pending1) begin
      gnt_valid = 1'b1;
      gnt_port  = 1'b1;
    end
    gnt_req = gnt_port ? slot1 : slot0;
  end

  assign issue_read = gnt_valid & gnt_req.is_read;

  // RAM issue: the granted slot drives the bus, otherwise everything is idle-zero.
  always_comb begin
    mem_addr  = '0;
    mem_rstrb = 1'b0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (gnt_valid) begin
      mem_addr = gnt_req.addr;
      if (gnt_req.is_read) begin
        mem_rstrb = 1'b1;
      end else begin
        mem_wdata = gnt_req.wdata;
        mem_wmask = gnt_req.wmask;
      end
    end
  end

  // Port 0 request slot. Capture and grant are exclusive: capture needs the slot empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending0 <= 1'b0;
      slot0    <= '0;
    end else if (req0) begin
      pending0      <= 1'b1;
      slot0.addr    <= m0_addr;
      slot0.wdata   <= m0_wdata;
      slot0.wmask   <= m0_wmask;
      slot0.is_read <= ~(|m0_wmask);
    end else if (gnt_valid && !gnt_port) begin
      pending0 <= 1'b0;
    end
  end

  // Port 1 request slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending1 <= 1'b0;
      slot1    <= '0;
    end else if (req1) begin
      pending1      <= 1'b1;
      slot1.addr    <= m1_addr;
      slot1.wdata   <= m1_wdata;
      slot1.wmask   <= m1_wmask;
      slot1.is_read <= ~(|m1_wmask);
    end else if (gnt_valid && gnt_port) begin
      pending1 <= 1'b0;
    end
  end

  // Arbitration history and read-return pipeline.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant  <= 1'b1;
      rd_inflight <= 1'b0;
      rd_owner    <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      if (gnt_valid) begin
        last_grant <= gnt_port;
      end
      rd_inflight <= issue_read;
      if (issue_read) begin
        rd_owner <= gnt_port;
      end
      if (rd_inflight) begin
        if (rd_owner) begin
          m1_rdata <= mem_rdata;
        end else begin
          m0_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter2.sv
// Directed bench for mem_arbiter2: RAM model, shadow memory and per-port
// expected-read queues, plus a fixed-priority instance under continuous load.
module tb_mem_arbiter2;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [AW-1:0] m0_addr, m1_addr;
  logic          m0_rstrb, m1_rstrb;
  logic [31:0]   m0_wdata, m1_wdata;
  logic [3:0]    m0_wmask, m1_wmask;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          m0_busy, m1_busy;
  logic [AW-1:0] mem_addr;
  logic          mem_rstrb;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic [31:0]   ram_q = 32'h0;

  logic [AW-1:0] f0_addr = 32'h100, f1_addr = 32'h104;
  logic [31:0]   f0_wdata = 32'hF0F0_F0F0, f1_wdata = 32'h0F0F_0F0F;
  logic [3:0]    f0_wmask = 4'h0, f1_wmask = 4'h0;
  logic [31:0]   f0_rdata, f1_rdata;
  logic          f0_busy, f1_busy;
  logic [AW-1:0] f_mem_addr;
  logic          f_mem_rstrb;
  logic [31:0]   f_mem_wdata;
  logic [3:0]    f_mem_wmask;

  logic [31:0] ram    [0:255] = '{default: 32'h0};
  logic [31:0] shadow [0:255] = '{default: 32'h0};
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  logic        bad_wr80 = 1'b0;

  int checks = 0;
  int failures = 0;
  int n0 = 0;
  int n1 = 0;

  always #5 clk = ~clk;

  mem_arbiter2 #(.ADDR_WIDTH(AW), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .resetn(resetn),
    .m0_addr(m0_addr), .m0_rstrb(m0_rstrb), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_rdata(m0_rdata), .m0_busy(m0_busy),
    .m1_addr(m1_addr), .m1_rstrb(m1_rstrb), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_rdata(m1_rdata), .m1_busy(m1_busy),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(ram_q)
  );

  mem_arbiter2 #(.ADDR_WIDTH(AW), .FIXED_PRIO(1'b1)) u_fix (
    .clk(clk), .resetn(resetn),
    .m0_addr(f0_addr), .m0_rstrb(1'b0), .m0_wdata(f0_wdata), .m0_wmask(f0_wmask),
    .m0_rdata(f0_rdata), .m0_busy(f0_busy),
    .m1_addr(f1_addr), .m1_rstrb(1'b0), .m1_wdata(f1_wdata), .m1_wmask(f1_wmask),
    .m1_rdata(f1_rdata), .m1_busy(f1_busy),
    .mem_addr(f_mem_addr), .mem_rstrb(f_mem_rstrb), .mem_wdata(f_mem_wdata), .mem_wmask(f_mem_wmask),
    .mem_rdata(32'h0)
  );

  // Single-ported RAM: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rstrb) ram_q <= ram[mem_addr[9:2]];
    for (int b = 0; b < 4; b++)
      if (mem_wmask[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    if ((|mem_wmask) && mem_addr == 32'h80) bad_wr80 <= 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_addr = '0; m0_rstrb = 1'b0; m0_wdata = '0; m0_wmask = '0;
    m1_addr = '0; m1_rstrb = 1'b0; m1_wdata = '0; m1_wmask = '0;
  endtask

  // Drive a one-cycle request; tracked requests update the shadow or queue an expected read.
  task automatic drive(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask, input logic rd, input bit track);
    if (port == 0) begin
      m0_addr = addr; m0_wdata = wdata; m0_wmask = wmask; m0_rstrb = rd;
    end else begin
      m1_addr = addr; m1_wdata = wdata; m1_wmask = wmask; m1_rstrb = rd;
    end
    if (track) begin
      if (wmask != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (wmask[b]) shadow[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
      end else if (rd) begin
        if (port == 0) exp_q0.push_back(shadow[addr[9:2]]);
        else           exp_q1.push_back(shadow[addr[9:2]]);
      end
    end
  endtask

  function automatic logic busy_of(input int port);
    return (port == 0) ? m0_busy : m1_busy;
  endfunction

  task automatic wait_idle(input int port, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (!busy_of(port)) return;
      tick();
    end
    chk("busy_timeout", 32'(busy_of(port)), 32'h0);
  endtask

  task automatic complete_read(input int port, input string tag);
    logic [31:0] exp;
    wait_idle(port, 8);
    exp = 32'hFFFF_FFFF;
    if (port == 0) begin
      if (exp_q0.size() > 0) exp = exp_q0.pop_front();
      chk(tag, m0_rdata, exp);
    end else begin
      if (exp_q1.size() > 0) exp = exp_q1.pop_front();
      chk(tag, m1_rdata, exp);
    end
  endtask

  initial begin
    logic [31:0] pre_addr [3];
    logic [31:0] pre_data [3];
    pre_addr = '{32'h0, 32'h4, 32'h20};
    pre_data = '{32'h1111_1111, 32'h2222_2222, 32'hDEAD_BEEF};

    // Reset state
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m0_busy", 32'(m0_busy), 32'h0);
    chk("rst_m1_busy", 32'(m1_busy), 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    chk("rst_mem_rstrb", 32'(mem_rstrb), 32'h0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    resetn = 1'b1;
    tick();

    // Preload RAM through port 1
    for (int i = 0; i < 3; i++) begin
      drive(1, pre_addr[i], pre_data[i], 4'hF, 1'b0, 1'b1);
      tick();
      idle_inputs();
      wait_idle(1, 8);
    end

    // Byte write with rstrb also set: the write wins
    drive(1, 32'h40, 32'h1122_3344, 4'b0010, 1'b1, 1'b1);
    tick();
    idle_inputs();
    chk("bw_c1_wmask", 32'(mem_wmask), 32'h2);
    chk("bw_c1_addr", mem_addr, 32'h40);
    chk("bw_c1_wdata", mem_wdata, 32'h1122_3344);
    chk("bw_c1_rstrb", 32'(mem_rstrb), 32'h0);
    chk("bw_c1_busy", 32'(m1_busy), 32'h1);
    tick();
    chk("bw_c2_busy", 32'(m1_busy), 32'h0);
    chk("bw_c2_wmask", 32'(mem_wmask), 32'h0);

    // Single uncontended read
    drive(0, 32'h20, 32'h0, 4'h0, 1'b1, 1'b1);
    tick();
    idle_inputs();
    chk("rd_c1_rstrb", 32'(mem_rstrb), 32'h1);
    chk("rd_c1_addr", mem_addr, 32'h20);
    chk("rd_c1_busy", 32'(m0_busy), 32'h1);
    tick();
    chk("rd_c2_busy", 32'(m0_busy), 32'h1);
    chk("rd_c2_rstrb", 32'(mem_rstrb), 32'h0);
    tick();
    chk("rd_c3_busy", 32'(m0_busy), 32'h0);
    complete_read(0, "rd_c3_rdata");
    chk("rd_m1_untouched", m1_rdata, 32'h0);

    // Byte-write readback
    drive(1, 32'h40, 32'h0, 4'h0, 1'b1, 1'b1);
    tick();
    idle_inputs();
    complete_read(1, "bw_readback");

    // Reset in the middle of a read
    drive(0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
    tick();
    idle_inputs();
    tick();
    resetn = 1'b0;
    #1;
    chk("rstmid_busy", 32'(m0_busy), 32'h0);
    chk("rstmid_rdata", m0_rdata, 32'h0);
    chk("rstmid_rstrb", 32'(mem_rstrb), 32'h0);
    chk("rstmid_m1_rdata", m1_rdata, 32'h0);
    tick();
    resetn = 1'b1;
    repeat (4) tick();
    chk("rstmid_post_busy", 32'(m0_busy), 32'h0);
    chk("rstmid_post_rdata", m0_rdata, 32'h0);

    // Tie right after reset: port 0 first
    drive(0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1);
    drive(1, 32'h4, 32'h0, 4'h0, 1'b1, 1'b1);
    tick();
    idle_inputs();
    chk("tie1_c1_addr", mem_addr, 32'h0);
    chk("tie1_c1_rstrb", 32'(mem_rstrb), 32'h1);
    chk("tie1_c1_busy0", 32'(m0_busy), 32'h1);
    chk("tie1_c1_busy1", 32'(m1_busy), 32'h1);
    tick();
    chk("tie1_c2_addr", mem_addr, 32'h4);
    chk("tie1_c2_rstrb", 32'(mem_rstrb), 32'h1);
    tick();
    chk("tie1_c3_busy0", 32'(m0_busy), 32'h0);
    complete_read(0, "tie1_c3_rdata0");
    chk("tie1_c3_busy1", 32'(m1_busy), 32'h1);
    chk("tie1_c3_rdata1_old", m1_rdata, 32'h0);
    tick();
    chk("tie1_c4_busy1", 32'(m1_busy), 32'h0);
    complete_read(1, "tie1_c4_rdata1");

    // Solo port-0 read leaves port 0 as last grant, so the next tie goes to port 1
    drive(0, 32'h4, 32'h0, 4'h0, 1'b1, 1'b1);
    tick();
    idle_inputs();
    complete_read(0, "solo_rdata0");
    drive(0, 32'h20, 32'h0, 4'h0, 1'b1, 1'b1);
    drive(1, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1);
    tick();
    idle_inputs();
    chk("tie2_c1_addr", mem_addr, 32'h0);
    chk("tie2_c1_rstrb", 32'(mem_rstrb), 32'h1);
    tick();
    chk("tie2_c2_addr", mem_addr, 32'h20);
    tick();
    chk("tie2_c3_busy0", 32'(m0_busy), 32'h1);
    complete_read(1, "tie2_c3_rdata1");
    tick();
    complete_read(0, "tie2_c4_rdata0");

    // Write pulse while busy is ignored
    drive(0, 32'h4, 32'h0, 4'h0, 1'b1, 1'b1);
    tick();
    chk("viol_busy", 32'(m0_busy), 32'h1);
    m0_rstrb = 1'b0;
    m0_addr  = 32'h80;
    m0_wdata = 32'hBAD0_BAD0;
    m0_wmask = 4'hF;
    tick();
    idle_inputs();
    complete_read(0, "viol_rdata");
    repeat (3) tick();
    chk("viol_no_wr80", 32'(bad_wr80), 32'h0);
    chk("viol_idle_busy", 32'(m0_busy), 32'h0);

    // Fixed priority under continuous write load from both ports
    for (int i = 0; i < 20; i++) begin
      f0_wmask = f0_busy ? 4'h0 : 4'hF;
      f1_wmask = f1_busy ? 4'h0 : 4'hF;
      if (f0_busy) chk("prio_p0_wins", f_mem_addr, 32'h100);
      if ((|f_mem_wmask) && f_mem_addr == 32'h104) begin
        n1++;
        chk("prio_p1_gap", 32'(f0_busy), 32'h0);
      end
      if ((|f_mem_wmask) && f_mem_addr == 32'h100) begin
        n0++;
        chk("prio_p0_wdata", f_mem_wdata, 32'hF0F0_F0F0);
      end
      tick();
    end
    f0_wmask = 4'h0;
    f1_wmask = 4'h0;
    chk("prio_n0", 32'(n0), 32'd10);
    chk("prio_n1", 32'(n1), 32'd9);
    chk("prio_no_rstrb", 32'(f_mem_rstrb), 32'h0);
    chk("prio_rdata0_unchanged", f0_rdata, 32'h0);
    chk("prio_rdata1_unchanged", f1_rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
